// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter
// Description : Shares the register-file write port between the pipeline
//               writeback stage and a multi-cycle unit.  MCU results are
//               buffered in a small FIFO; the pipeline has priority, and an
//               anti-starvation counter stalls the pipeline for one cycle so
//               a waiting FIFO head can drain.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_port_arbiter #(
    parameter int XLEN         = 64,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWrite_W,
    input  logic [4:0]      Rd_W,
    input  logic [XLEN-1:0] Result_W,
    input  logic            MC_Valid,
    output logic            MC_Ready,
    input  logic [4:0]      MC_Rd,
    input  logic [XLEN-1:0] MC_Data,
    input  logic [4:0]      Rs1_D,
    input  logic [4:0]      Rs2_D,
    output logic            PendHit_D,
    output logic            Stall_WB,
    output logic            RF_WE,
    output logic [4:0]      RF_Rd,
    output logic [XLEN-1:0] RF_WD
);

    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int c_STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_STV_W-1:0] c_LIMIT = c_STV_W'(STARVE_LIMIT);

    // FIFO storage; live marks entries whose write has not been superseded
    logic [4:0]            rd_q   [FIFO_DEPTH];
    logic [4:0]            rd_d   [FIFO_DEPTH];
    logic [XLEN-1:0]       data_q [FIFO_DEPTH];
    logic [XLEN-1:0]       data_d [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] live_q, live_d;
    logic [c_PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [c_PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [c_CNT_W-1:0]    count_q, count_d;
    logic [c_STV_W-1:0]    starve_q, starve_d;

    logic w_full;
    logic w_empty;
    logic w_head_live;
    logic w_head_dead;
    logic w_stall;
    logic w_pipe_req;
    logic w_pipe_wr;
    logic w_head_grant;
    logic w_pop;
    logic w_push;
    logic w_enq;

    // Arbitration decode: who owns the write port this cycle
    always_comb begin
        w_full       = (count_q == c_DEPTH);
        w_empty      = (count_q == '0);
        w_head_live  = !w_empty && live_q[rd_ptr_q];
        w_head_dead  = !w_empty && !live_q[rd_ptr_q];
        w_stall      = !rst && w_head_live && (starve_q == c_LIMIT);
        w_pipe_req   = !rst && RegWrite_W && (Rd_W != 5'd0);
        w_pipe_wr    = w_pipe_req && !w_stall;
        w_head_grant = !rst && (w_stall || (!w_pipe_req && w_head_live));
        // A killed head leaves without touching the port
        w_pop        = w_head_grant || (!rst && w_head_dead);
        // Full blocks acceptance even when a pop frees a slot this cycle
        w_push       = !rst && MC_Valid && !w_full;
        w_enq        = w_push && (MC_Rd != 5'd0);
    end

    // Port outputs, combinational from state and current inputs
    always_comb begin
        MC_Ready  = !rst && !w_full;
        Stall_WB  = w_stall;
        RF_WE     = w_head_grant || w_pipe_wr;
        RF_Rd     = w_head_grant ? rd_q[rd_ptr_q]   : Rd_W;
        RF_WD     = w_head_grant ? data_q[rd_ptr_q] : Result_W;
        PendHit_D = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (!rst && live_q[i] && (rd_q[i] != 5'd0) &&
                ((rd_q[i] == Rs1_D) || (rd_q[i] == Rs2_D))) begin
                PendHit_D = 1'b1;
            end
        end
    end

    // FIFO next state: pop, enqueue, then kill entries the pipeline supersedes
    always_comb begin
        rd_d     = rd_q;
        data_d   = data_q;
        live_d   = live_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (w_pop) begin
            live_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = rd_ptr_q + c_PTR_W'(1);
        end
        if (w_enq) begin
            rd_d[wr_ptr_q]   = MC_Rd;
            data_d[wr_ptr_q] = MC_Data;
            live_d[wr_ptr_q] = 1'b1;
            wr_ptr_d         = wr_ptr_q + c_PTR_W'(1);
        end
        // The pipeline instruction is younger than anything buffered, so its
        // write makes older results to the same register obsolete.
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (w_pipe_wr && (rd_d[i] == Rd_W)) begin
                live_d[i] = 1'b0;
            end
        end

        case ({w_enq, w_pop})
            2'b10:   count_d = count_q + c_CNT_W'(1);
            2'b01:   count_d = count_q - c_CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Starvation counter: counts cycles a non-empty FIFO fails to pop
    always_comb begin
        if (w_empty || w_pop) begin
            starve_d = '0;
        end else if (starve_q == c_LIMIT) begin
            starve_d = starve_q;
        end else begin
            starve_d = starve_q + c_STV_W'(1);
        end
    end

    // State registers; payload storage needs no reset since live gates it
    always_ff @(posedge clk) begin
        rd_q   <= rd_d;
        data_q <= data_d;
        if (rst) begin
            live_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
        end else begin
            live_q   <= live_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_port_arbiter
// Description : Self-checking bench for wb_port_arbiter: directed scenarios
//               followed by randomized traffic against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;

    localparam int c_XLEN  = 64;
    localparam int c_DEPTH = 2;
    localparam int c_LIMIT = 4;

    logic              clk;
    logic              rst;
    logic              RegWrite_W;
    logic [4:0]        Rd_W;
    logic [c_XLEN-1:0] Result_W;
    logic              MC_Valid;
    logic              MC_Ready;
    logic [4:0]        MC_Rd;
    logic [c_XLEN-1:0] MC_Data;
    logic [4:0]        Rs1_D;
    logic [4:0]        Rs2_D;
    logic              PendHit_D;
    logic              Stall_WB;
    logic              RF_WE;
    logic [4:0]        RF_Rd;
    logic [c_XLEN-1:0] RF_WD;

    wb_port_arbiter #(
        .XLEN        (c_XLEN),
        .FIFO_DEPTH  (c_DEPTH),
        .STARVE_LIMIT(c_LIMIT)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .RegWrite_W(RegWrite_W),
        .Rd_W      (Rd_W),
        .Result_W  (Result_W),
        .MC_Valid  (MC_Valid),
        .MC_Ready  (MC_Ready),
        .MC_Rd     (MC_Rd),
        .MC_Data   (MC_Data),
        .Rs1_D     (Rs1_D),
        .Rs2_D     (Rs2_D),
        .PendHit_D (PendHit_D),
        .Stall_WB  (Stall_WB),
        .RF_WE     (RF_WE),
        .RF_Rd     (RF_Rd),
        .RF_WD     (RF_WD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Staged stimulus, applied at the next falling edge
    logic              s_rst, s_regw, s_mcv;
    logic [4:0]        s_rdw, s_mcrd, s_rs1, s_rs2;
    logic [c_XLEN-1:0] s_res, s_mcd;

    // Outputs observed in the most recent cycle
    logic              o_ready, o_stall, o_we, o_ph;
    logic [4:0]        o_rd;
    logic [c_XLEN-1:0] o_wd;

    // Reference model: buffered MCU results in arrival order
    typedef struct {
        logic [4:0]        rd;
        logic [c_XLEN-1:0] data;
        bit                live;
    } ent_t;
    ent_t m_q[$];
    int   m_starve = 0;

    task automatic idle();
        s_rst = 1'b0; s_regw = 1'b0; s_rdw = '0; s_res = '0;
        s_mcv = 1'b0; s_mcrd = '0; s_mcd = '0; s_rs1 = '0; s_rs2 = '0;
    endtask

    task automatic cycle();
        bit                full, hl, e_stall, pipe, pop, e_we, e_ph, hs, was_empty;
        logic [4:0]        e_rd;
        logic [c_XLEN-1:0] e_wd;
        @(negedge clk);
        rst = s_rst; RegWrite_W = s_regw; Rd_W = s_rdw; Result_W = s_res;
        MC_Valid = s_mcv; MC_Rd = s_mcrd; MC_Data = s_mcd; Rs1_D = s_rs1; Rs2_D = s_rs2;
        #1;
        o_ready = MC_Ready; o_stall = Stall_WB; o_we = RF_WE; o_ph = PendHit_D;
        o_rd = RF_Rd; o_wd = RF_WD;
        if (s_rst) begin
            check("rst_ready", o_ready, 0);
            check("rst_we",    o_we,    0);
            check("rst_stall", o_stall, 0);
            check("rst_ph",    o_ph,    0);
            m_q.delete();
            m_starve = 0;
        end else begin
            full    = (m_q.size() == c_DEPTH);
            hl      = (m_q.size() > 0) && m_q[0].live;
            e_stall = hl && (m_starve == c_LIMIT);
            pipe    = s_regw && (s_rdw != 0);
            pop = 0; e_we = 0; e_rd = '0; e_wd = '0;
            if (e_stall || (!pipe && hl)) begin
                e_we = 1; e_rd = m_q[0].rd; e_wd = m_q[0].data; pop = 1;
            end else if (pipe) begin
                e_we = 1; e_rd = s_rdw; e_wd = s_res;
            end
            if (m_q.size() > 0 && !m_q[0].live) pop = 1;
            e_ph = 0;
            foreach (m_q[i])
                if (m_q[i].live && m_q[i].rd != 0 && (m_q[i].rd == s_rs1 || m_q[i].rd == s_rs2))
                    e_ph = 1;
            check("ready", o_ready, !full);
            check("stall", o_stall, e_stall);
            check("we",    o_we,    e_we);
            check("pendhit", o_ph,  e_ph);
            if (e_we) begin
                check("rf_rd", o_rd, e_rd);
                check("rf_wd", o_wd, e_wd);
            end
            // Advance the model to the next cycle
            hs        = s_mcv && !full;
            was_empty = (m_q.size() == 0);
            if (pop) void'(m_q.pop_front());
            if (pipe && !e_stall)
                foreach (m_q[i]) if (m_q[i].rd == s_rdw) m_q[i].live = 0;
            if (hs && s_mcrd != 0)
                m_q.push_back('{s_mcrd, s_mcd, !(pipe && !e_stall && s_mcrd == s_rdw)});
            if (was_empty || pop)       m_starve = 0;
            else if (m_starve < c_LIMIT) m_starve++;
        end
    endtask

    task automatic do_reset();
        idle(); s_rst = 1'b1; s_mcv = 1'b1; s_mcrd = 5'd4;
        cycle(); cycle();
        idle();
    endtask

    initial begin
        idle();
        rst = 1'b1; RegWrite_W = 0; Rd_W = 0; Result_W = 0; MC_Valid = 0;
        MC_Rd = 0; MC_Data = 0; Rs1_D = 0; Rs2_D = 0;

        // T1: reset with MC_Valid asserted, then FIFO empty after release
        do_reset();
        cycle();
        check("t1_ready_after", o_ready, 1);
        check("t1_we_after",    o_we,    0);

        // T2: idle drain with one-cycle latency
        do_reset();
        s_mcv = 1; s_mcrd = 5'd5; s_mcd = 64'hAB; s_rs1 = 5'd5;
        cycle();
        check("t2_c0_we", o_we, 0);
        check("t2_c0_ph", o_ph, 0);
        idle(); s_rs1 = 5'd5;
        cycle();
        check("t2_c1_we", o_we, 1);
        check("t2_c1_rd", o_rd, 5);
        check("t2_c1_wd", o_wd, 64'hAB);
        check("t2_c1_ph", o_ph, 1);
        cycle();
        check("t2_c2_ph", o_ph, 0);
        check("t2_c2_we", o_we, 0);

        // T3: pipeline priority then starvation stall
        do_reset();
        s_regw = 1; s_rdw = 5'd3; s_res = 64'h33; s_mcv = 1; s_mcrd = 5'd7; s_mcd = 64'h77;
        cycle();
        s_mcv = 0;
        for (int k = 1; k <= 6; k++) begin
            cycle();
            check("t3_stall", o_stall, (k == 5));
            check("t3_rd",    o_rd,    (k == 5) ? 5'd7 : 5'd3);
        end

        // T4: full FIFO holds off the third result until after a pop
        do_reset();
        s_regw = 1; s_rdw = 5'd3; s_mcv = 1; s_mcrd = 5'd10; s_mcd = 64'hA;
        cycle();
        s_mcrd = 5'd11; s_mcd = 64'hB;
        cycle();
        s_mcrd = 5'd12; s_mcd = 64'hC;
        for (int k = 2; k <= 6; k++) begin
            cycle();
            check("t4_ready", o_ready, (k == 6));
            if (k == 5) check("t4_stall", o_stall, 1);
        end
        idle();
        for (int k = 0; k < 4; k++) cycle();

        // T5: pipeline write kills an older buffered result
        do_reset();
        s_regw = 1; s_rdw = 5'd3; s_mcv = 1; s_mcrd = 5'd9; s_mcd = 64'd1;
        cycle();
        idle(); s_regw = 1; s_rdw = 5'd9; s_res = 64'd2; s_rs1 = 5'd9;
        cycle();
        check("t5_rd", o_rd, 9);
        check("t5_wd", o_wd, 2);
        check("t5_ph_live", o_ph, 1);
        idle(); s_rs1 = 5'd9;
        cycle();
        check("t5_ph_dead", o_ph, 0);
        check("t5_we_dead", o_we, 0);

        // T6: writes to x0 are accepted and dropped
        do_reset();
        s_mcv = 1; s_mcrd = 5'd0; s_mcd = 64'h55;
        cycle();
        check("t6_ready", o_ready, 1);
        idle();
        cycle();
        check("t6_we1", o_we, 0);
        cycle();
        check("t6_we2", o_we, 0);

        // Randomized traffic, including occasional mid-run reset
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            s_rst  = ($urandom_range(0, 99) == 0);
            s_regw = ($urandom_range(0, 99) < 65);
            s_rdw  = 5'($urandom_range(0, 7));
            s_res  = {$urandom, $urandom};
            s_mcv  = ($urandom_range(0, 99) < 50);
            s_mcrd = 5'($urandom_range(0, 7));
            s_mcd  = {$urandom, $urandom};
            s_rs1  = 5'($urandom_range(0, 7));
            s_rs2  = 5'($urandom_range(0, 7));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
